pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Stall/flush controller for the 5-stage semiMIPS pipeline. It sequences the PC, IF/ID, ID/EX and EX/MEM pipeline registers using three hazard sources:
- load-use hazards detected in ID;
- branch/jump resolution at the EX/MEM outputs;
- a data-memory ready handshake with a timeout FSM.

It produces write-enable, hold and flush strobes only; it never touches datapath values.

Parameters:
TMO_W, 8, width of the memory-wait timeout counter
MEM_TIMEOUT, 200, cycles of mem_ready low tolerated before error (must be < 2^TMO_W)
STAT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  synchronous reset, active-high
ifid_rs  in  5  rs field of instruction in IF/ID
ifid_rt  in  5  rt field of instruction in IF/ID
idex_memrd  in  1  ID/EX stage holds a load
idex_rt  in  5  destination rt of the load in ID/EX
exmem_memrd  in  1  EX/MEM memrdout
exmem_memwr  in  1  EX/MEM memwrout
exmem_bbeq, exmem_bbne, exmem_bblez, exmem_bbgtz, exmem_jump  in  1 each  EX/MEM branch/jump controls
exmem_zero, exmem_negative  in  1 each  EX/MEM ALU flags
mem_ready  in  1  data memory completed access this cycle
pc_write  out  1  PC update enable
pc_sel  out  2  0 = PC+4, 1 = branch address, 2 = jump address
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID load NOP
idex_flush  out  1  ID/EX load bubble (control fields zero)
exmem_hold  out  1  EX/MEM keep contents
exmem_flush  out  1  EX/MEM load bubble
mem_err  out  1  sticky memory timeout error

Behaviour:
- Reset (rst high at a clk edge):
  - Registered effect: state <= RUN, timeout counter <= 0, mem_err <= 0.
  - Outputs while rst is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1, exmem_hold=0, pc_sel=0.
- Outputs are a combinational decode of inputs and registered state.
- Only state and the counters are registered; no added pipeline latency.
- FSM states: RUN, MEMWAIT, ERR.
- mem_access = exmem_memrd | exmem_memwr.
- taken = exmem_jump | (exmem_bbeq & zero) | (exmem_bbne & ~zero) | (exmem_bblez & (zero | negative)) | (exmem_bbgtz & ~zero & ~negative).
- loaduse = idex_memrd & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
- RUN decode, priority order (highest first):
  1. mem_access & ~mem_ready: freeze. pc_write=0, ifid_write=0, exmem_hold=1, idex_flush=1, no other flushes. Next state MEMWAIT, counter <= 1.
  2. taken: pc_write=1, pc_sel=2 if exmem_jump else 1. ifid_flush=1, idex_flush=1, exmem_flush=1 for exactly that cycle.
  3. loaduse: pc_write=0, ifid_write=0, idex_flush=1 for one cycle.
  4. Otherwise: pc_write=1, ifid_write=1, pc_sel=0, all flushes 0, exmem_hold=0.
- MEMWAIT:
  - Freeze outputs as in RUN item 1; counter increments each cycle.
  - When mem_ready=1: apply the RUN decode in that same cycle (branch/loaduse still honoured) and go to RUN; counter <= 0.
  - When counter == MEM_TIMEOUT with mem_ready=0: go to ERR and set mem_err.
  - mem_ready arriving in the same cycle as the timeout wins; no error is raised.
- ERR: permanent freeze (pc_write=0, ifid_write=0, exmem_hold=1). mem_err=1 until rst.
- Reset mid-MEMWAIT: returns to RUN with the counter cleared.
- The counter saturates; it never wraps.

Optional Feature:
Macro PIPE_HAZARD_STATS_EN.
- Defined: adds three output ports, all cleared by rst and saturating at all-ones (STAT_W bits):
  - stat_ldstall: count of loaduse stall cycles.
  - stat_flush: count of taken-branch/jump flush cycles.
  - stat_memwait: count of cycles frozen by the memory handshake.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load in ID/EX with idex_rt=5, IF/ID rs=5 -> exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1. Then normal flow resumes.
- Same load with idex_rt=0 and ifid_rs=0 -> no stall.
- exmem_bbeq=1, zero=1 -> pc_sel=1, pc_write=1, all three flushes high for 1 cycle. With bbgtz=1, negative=1 -> not taken, pc_sel=0.
- exmem_memrd=1, mem_ready low for 3 cycles then high -> 3 frozen cycles with exmem_hold=1. Release cycle has exmem_hold=0, then RUN; mem_err stays 0.
- MEM_TIMEOUT=4, mem_ready held low -> mem_err rises after 4 wait cycles and remains high. Asserting rst for 1 cycle -> mem_err=0, state RUN.
- Branch taken and loaduse in the same cycle -> branch wins (pc_sel=1, flushes), no stall. Memory freeze together with a taken branch -> freeze wins until mem_ready.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: EX/MEM, ID/EX, IF/ID hazard inputs and the stall/flush strobes.
// The master side is the pipeline datapath; the slave side is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       idex_memrd;
  logic [4:0] idex_rt;
  logic       exmem_memrd;
  logic       exmem_memwr;
  logic       exmem_bbeq;
  logic       exmem_bbne;
  logic       exmem_bblez;
  logic       exmem_bbgtz;
  logic       exmem_jump;
  logic       exmem_zero;
  logic       exmem_negative;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_sel;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_hold;
  logic       exmem_flush;
  logic       mem_err;

  modport master (
    output ifid_rs, ifid_rt, idex_memrd, idex_rt, exmem_memrd, exmem_memwr,
           exmem_bbeq, exmem_bbne, exmem_bblez, exmem_bbgtz, exmem_jump,
           exmem_zero, exmem_negative, mem_ready,
    input  pc_write, pc_sel, ifid_write, ifid_flush, idex_flush,
           exmem_hold, exmem_flush, mem_err
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_memrd, idex_rt, exmem_memrd, exmem_memwr,
           exmem_bbeq, exmem_bbne, exmem_bblez, exmem_bbgtz, exmem_jump,
           exmem_zero, exmem_negative, mem_ready,
    output pc_write, pc_sel, ifid_write, ifid_flush, idex_flush,
           exmem_hold, exmem_flush, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: strobes are a same-cycle decode of inputs and FSM state,
// memory backpressure freezes the front end until mem_ready or timeout; PIPE_HAZARD_STATS_EN adds stat counters.
module pipe_hazard_ctrl #(
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 200,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_ldstall,
  output logic [STAT_W-1:0] stat_flush,
  output logic [STAT_W-1:0] stat_memwait
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERR     = 2'd2
  } state_e;

  localparam logic [1:0]       PC_SEQ    = 2'd0;
  localparam logic [1:0]       PC_BRANCH = 2'd1;
  localparam logic [1:0]       PC_JUMP   = 2'd2;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic             mem_err_q, mem_err_d;

  logic       mem_access, taken, loaduse;
  logic       run_dec, freeze, do_flush, do_stall;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, exmem_flush;
  logic [1:0] pc_sel;

  assign mem_access = hz.exmem_memrd | hz.exmem_memwr;

  assign taken = hz.exmem_jump
               | (hz.exmem_bbeq  &  hz.exmem_zero)
               | (hz.exmem_bbne  & ~hz.exmem_zero)
               | (hz.exmem_bblez & (hz.exmem_zero | hz.exmem_negative))
               | (hz.exmem_bbgtz & ~hz.exmem_zero & ~hz.exmem_negative);

  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign loaduse = hz.idex_memrd && (hz.idex_rt != 5'd0)
                && ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));

  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    mem_err_d   = mem_err_q;
    run_dec     = 1'b0;
    freeze      = 1'b0;
    do_flush    = 1'b0;
    do_stall    = 1'b0;
    pc_write    = 1'b1;
    pc_sel      = PC_SEQ;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    exmem_flush = 1'b0;

    case (state_q)
      ST_RUN: run_dec = 1'b1;
      ST_MEMWAIT: begin
        // A ready arriving on the timeout cycle still counts as success.
        if (hz.mem_ready) begin
          run_dec = 1'b1;
        end else begin
          freeze = 1'b1;
          if (tmo_q == TMO_LIMIT) begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end
      ST_ERR:  freeze  = 1'b1;
      default: state_d = ST_RUN;
    endcase

    if (run_dec) begin
      state_d = ST_RUN;
      tmo_d   = '0;
      if (mem_access && !hz.mem_ready) begin
        freeze  = 1'b1;
        state_d = ST_MEMWAIT;
        tmo_d   = TMO_W'(1);
      end else if (taken) begin
        do_flush = 1'b1;
      end else if (loaduse) begin
        do_stall = 1'b1;
      end
    end

    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
      idex_flush = 1'b1;
    end else if (do_flush) begin
      // IF/ID still loads so that the NOP actually lands in it.
      pc_sel      = hz.exmem_jump ? PC_JUMP : PC_BRANCH;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (do_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end

    if (rst) begin
      pc_write    = 1'b0;
      pc_sel      = PC_SEQ;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_hold  = 1'b0;
      exmem_flush = 1'b1;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.pc_sel      = pc_sel;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_hold  = exmem_hold;
  assign hz.exmem_flush = exmem_flush;
  assign hz.mem_err     = mem_err_q;

`ifdef PIPE_HAZARD_STATS_EN
  logic [STAT_W-1:0] stat_ldstall_q, stat_flush_q, stat_memwait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ldstall_q <= '0;
      stat_flush_q   <= '0;
      stat_memwait_q <= '0;
    end else begin
      if (do_stall && (stat_ldstall_q != '1)) stat_ldstall_q <= stat_ldstall_q + STAT_W'(1);
      if (do_flush && (stat_flush_q != '1))   stat_flush_q   <= stat_flush_q + STAT_W'(1);
      // The permanent error freeze is not a handshake wait.
      if (freeze && (state_q != ST_ERR) && (stat_memwait_q != '1))
        stat_memwait_q <= stat_memwait_q + STAT_W'(1);
    end
  end

  assign stat_ldstall = stat_ldstall_q;
  assign stat_flush   = stat_flush_q;
  assign stat_memwait = stat_memwait_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl, built with MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  pipe_hazard_ctrl_if hif ();

`ifdef PIPE_HAZARD_STATS_EN
  logic [15:0] stat_ldstall, stat_flush, stat_memwait;
`endif

  pipe_hazard_ctrl #(
    .TMO_W      (8),
    .MEM_TIMEOUT(4),
    .STAT_W     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hif.slave)
`ifdef PIPE_HAZARD_STATS_EN
    ,
    .stat_ldstall(stat_ldstall),
    .stat_flush  (stat_flush),
    .stat_memwait(stat_memwait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, pc_sel[1:0], ifid_write, ifid_flush, idex_flush, exmem_hold, exmem_flush, mem_err}
  localparam logic [8:0] NORM  = 9'b1_00_1_0_0_0_0_0;
  localparam logic [8:0] STALL = 9'b0_00_0_0_1_0_0_0;
  localparam logic [8:0] BR    = 9'b1_01_1_1_1_0_1_0;
  localparam logic [8:0] JMP   = 9'b1_10_1_1_1_0_1_0;
  localparam logic [8:0] FRZ   = 9'b0_00_0_0_1_1_0_0;
  localparam logic [8:0] ERRV  = 9'b0_00_0_0_1_1_0_1;
  localparam logic [8:0] RST0  = 9'b0_00_0_1_1_0_1_0;
  localparam logic [8:0] RST1  = 9'b0_00_0_1_1_0_1_1;

  logic [8:0] outs;
  assign outs = {hif.pc_write, hif.pc_sel, hif.ifid_write, hif.ifid_flush,
                 hif.idex_flush, hif.exmem_hold, hif.exmem_flush, hif.mem_err};

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    hif.ifid_rs = 5'd0;  hif.ifid_rt = 5'd0;
    hif.idex_memrd = 1'b0; hif.idex_rt = 5'd0;
    hif.exmem_memrd = 1'b0; hif.exmem_memwr = 1'b0;
    hif.exmem_bbeq = 1'b0; hif.exmem_bbne = 1'b0; hif.exmem_bblez = 1'b0;
    hif.exmem_bbgtz = 1'b0; hif.exmem_jump = 1'b0;
    hif.exmem_zero = 1'b0; hif.exmem_negative = 1'b0;
    hif.mem_ready = 1'b0;
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled on the falling edge.
  task automatic step(input string tag, input logic [8:0] exp);
    @(negedge clk);
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    step("reset", RST0);
    rst = 1'b0;
    step("idle", NORM);

    // Load-use through rs, then bubble has moved on.
    hif.idex_memrd = 1'b1; hif.idex_rt = 5'd5; hif.ifid_rs = 5'd5;
    step("ldu_rs", STALL);
    idle();
    step("ldu_resume", NORM);
    hif.idex_memrd = 1'b1; hif.idex_rt = 5'd7; hif.ifid_rt = 5'd7;
    step("ldu_rt", STALL);
    idle(); hif.idex_memrd = 1'b1;
    step("ldu_r0", NORM);
    hif.idex_rt = 5'd5; hif.ifid_rs = 5'd6; hif.ifid_rt = 5'd4;
    step("ldu_nomatch", NORM);

    // Branch/jump conditions.
    idle(); hif.exmem_bbeq = 1'b1; hif.exmem_zero = 1'b1;
    step("beq_taken", BR);
    idle();
    step("beq_after", NORM);
    hif.exmem_bbgtz = 1'b1; hif.exmem_negative = 1'b1;
    step("bgtz_neg", NORM);
    idle(); hif.exmem_bbgtz = 1'b1;
    step("bgtz_pos", BR);
    idle(); hif.exmem_bbne = 1'b1;
    step("bne_taken", BR);
    idle(); hif.exmem_bbne = 1'b1; hif.exmem_zero = 1'b1;
    step("bne_not", NORM);
    idle(); hif.exmem_bblez = 1'b1; hif.exmem_negative = 1'b1;
    step("blez_taken", BR);
    idle(); hif.exmem_jump = 1'b1;
    step("jump", JMP);
    idle(); hif.exmem_bbeq = 1'b1; hif.exmem_zero = 1'b1;
    hif.idex_memrd = 1'b1; hif.idex_rt = 5'd3; hif.ifid_rs = 5'd3;
    step("br_over_ldu", BR);

    // Three frozen cycles, then release.
    idle(); hif.exmem_memrd = 1'b1;
    for (int i = 0; i < 3; i++) step("mw_frz", FRZ);
    hif.mem_ready = 1'b1;
    step("mw_release", NORM);
    idle();
    step("mw_after", NORM);

    // Freeze beats a taken branch; branch honoured on the release cycle.
    hif.exmem_memwr = 1'b1; hif.exmem_bbeq = 1'b1; hif.exmem_zero = 1'b1;
    for (int i = 0; i < 2; i++) step("frz_over_br", FRZ);
    hif.mem_ready = 1'b1;
    step("br_on_release", BR);
    idle();
    step("br_rel_after", NORM);

    // Load-use honoured on the release cycle.
    hif.exmem_memrd = 1'b1;
    step("frz_ldu", FRZ);
    hif.mem_ready = 1'b1;
    hif.idex_memrd = 1'b1; hif.idex_rt = 5'd9; hif.ifid_rt = 5'd9;
    step("ldu_on_release", STALL);

    // Ready on the exact timeout cycle wins.
    idle(); hif.exmem_memrd = 1'b1;
    for (int i = 0; i < 4; i++) step("race_frz", FRZ);
    hif.mem_ready = 1'b1;
    step("race_ready", NORM);
    idle();
    step("race_no_err", NORM);

    // Timeout into sticky error.
    hif.exmem_memrd = 1'b1;
    for (int i = 0; i < 5; i++) step("tmo_frz", FRZ);
    step("tmo_err", ERRV);
    hif.mem_ready = 1'b1;
    step("err_sticky_rdy", ERRV);
    idle();
    step("err_sticky_idle", ERRV);
    rst = 1'b1;
    step("err_rst", RST1);
    rst = 1'b0;
    step("err_cleared", NORM);

    // Reset mid-wait returns to RUN.
    hif.exmem_memrd = 1'b1;
    for (int i = 0; i < 2; i++) step("mid_frz", FRZ);
    rst = 1'b1;
    step("mid_rst", RST0);
    rst = 1'b0; idle();
    step("mid_run", NORM);
    // Counter must restart from scratch: four frozen cycles are still short of the timeout.
    hif.exmem_memrd = 1'b1;
    for (int i = 0; i < 4; i++) step("mid_refrz", FRZ);
    hif.mem_ready = 1'b1;
    step("mid_rel", NORM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
